// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared MMIO offsets, STATUS bit indices and decode constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] OFF_CNT_LO  = 2'd0;
  localparam logic [1:0] OFF_CNT_HI  = 2'd1;
  localparam logic [1:0] OFF_TX_DATA = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_LEVEL_LSB = 2;
  localparam int ST_LEVEL_W   = 6;
  localparam int ST_OVF       = 8;
  localparam int ST_ERR       = 9;

  localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/dmem_tx_fifo.sv
// ============================================================================
// Module : dmem_tx_fifo
// Brief  : Byte-wide synchronous FIFO; a push into a full FIFO still succeeds
//          when a pop happens in the same cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_drop
);

  logic [7:0]    r_buf [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_valid = !o_empty;
  assign o_data  = r_buf[r_rd_ptr];
  assign o_level = r_level;

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_drop = i_push && !w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; validity is tracked solely by r_level.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module : dmem_responder
// Brief  : Data-port responder: byte-strobed RAM, 64-bit cycle counter and a
//          debug TX FIFO behind a 16-byte MMIO window. Reads are combinational.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [3:0]  Strobe,
  output logic [31:0] RD,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int TX_AW  = $clog2(TX_DEPTH);

  logic [31:0]     r_mem [MEM_WORDS];
  logic [63:0]     r_cnt;
  logic            r_ovf;
  logic            r_err;

  logic            w_ram_hit;
  logic            w_mmio_hit;
  logic [1:0]      w_off;
  logic [MEM_AW-1:0] w_ram_idx;
  logic            w_push;
  logic            w_wr_status;
  logic            w_wr_unmapped;
  logic            w_full;
  logic            w_empty;
  logic            w_drop;
  logic [TX_AW:0]  w_level;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_ram_hit     = (Addr[31:2] < 30'(MEM_WORDS));
  assign w_mmio_hit    = (Addr[31:4] == MMIO_BASE[31:4]);
  assign w_off         = Addr[3:2];
  assign w_ram_idx     = Addr[MEM_AW+1:2];
  assign w_unused      = ^Addr[1:0];

  assign w_push        = WE && w_mmio_hit && (w_off == OFF_TX_DATA) && Strobe[0];
  assign w_wr_status   = WE && w_mmio_hit && (w_off == OFF_STATUS);
  assign w_wr_unmapped = WE && !w_ram_hit && !w_mmio_hit;

  always_ff @(posedge clk) begin
    if (WE && w_ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (Strobe[i]) r_mem[w_ram_idx][8*i +: 8] <= WD[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 64'd1;
      if (w_wr_status) begin
        r_ovf <= 1'b0;
        r_err <= 1'b0;
      end else begin
        if (w_drop)        r_ovf <= 1'b1;
        if (w_wr_unmapped) r_err <= 1'b1;
      end
    end
  end

  dmem_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (WD[7:0]),
    .i_pop   (tx_ready),
    .o_valid (tx_valid),
    .o_data  (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_drop  (w_drop)
  );

  always_comb begin
    w_status                             = '0;
    w_status[ST_FULL]                    = w_full;
    w_status[ST_EMPTY]                   = w_empty;
    w_status[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(w_level);
    w_status[ST_OVF]                     = r_ovf;
    w_status[ST_ERR]                     = r_err;
  end

  always_comb begin
    RD = UNMAPPED_RD;
    if (w_ram_hit) begin
      RD = r_mem[w_ram_idx];
    end else if (w_mmio_hit) begin
      case (w_off)
        OFF_CNT_LO: RD = r_cnt[31:0];
        OFF_CNT_HI: RD = r_cnt[63:32];
        OFF_STATUS: RD = w_status;
        default:    RD = 32'h0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module : tb_dmem_responder
// Brief  : Directed and randomized checks of dmem_responder against a queue /
//          associative-array reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] A_CNT_LO  = 32'h8000_0000;
  localparam logic [31:0] A_CNT_HI  = 32'h8000_0004;
  localparam logic [31:0] A_TX      = 32'h8000_0008;
  localparam logic [31:0] A_STATUS  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic [3:0]  Strobe = '0;
  logic [31:0] RD;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [int];
  logic [7:0]  ref_q [$];
  bit          ref_ovf = 1'b0;
  bit          ref_err = 1'b0;
  logic [63:0] ref_cnt = '0;

  always #5 clk = ~clk;

  dmem_responder u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Addr     (Addr),
    .WD       (WD),
    .WE       (WE),
    .Strobe   (Strobe),
    .RD       (RD),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  function automatic bit is_ram(logic [31:0] a);
    return a < 32'd4096;
  endfunction

  function automatic bit is_mmio(logic [31:0] a);
    return a[31:4] == 28'h800_0000;
  endfunction

  function automatic bit rd_known(logic [31:0] a);
    if (is_ram(a)) return ref_mem.exists(int'(a[11:2]));
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    logic [31:0] s;
    if (is_ram(a)) return ref_mem[int'(a[11:2])];
    if (!is_mmio(a)) return 32'h0;
    case (a[3:2])
      2'd0: return ref_cnt[31:0];
      2'd1: return ref_cnt[63:32];
      2'd2: return 32'h0;
      default: begin
        s    = 32'h0;
        s[0] = (ref_q.size() == DEPTH);
        s[1] = (ref_q.size() == 0);
        s[7:2] = 6'(ref_q.size());
        s[8] = ref_ovf;
        s[9] = ref_err;
        return s;
      end
    endcase
  endfunction

  // Applies the current inputs to the model, then advances one clock edge.
  task automatic step();
    bit pop;
    bit push_ok;
    bit do_push;
    int idx;
    logic [31:0] w;
    pop     = tx_ready && (ref_q.size() > 0);
    push_ok = (ref_q.size() < DEPTH) || pop;
    do_push = 1'b0;
    if (WE) begin
      if (is_ram(Addr)) begin
        idx = int'(Addr[11:2]);
        if (ref_mem.exists(idx)) begin
          w = ref_mem[idx];
          for (int i = 0; i < 4; i++) if (Strobe[i]) w[8*i +: 8] = WD[8*i +: 8];
          ref_mem[idx] = w;
        end else if (Strobe == 4'hF) begin
          ref_mem[idx] = WD;
        end
      end else if (is_mmio(Addr)) begin
        if (Addr[3:2] == 2'd2 && Strobe[0]) begin
          if (push_ok) do_push = 1'b1;
          else ref_ovf = 1'b1;
        end else if (Addr[3:2] == 2'd3) begin
          ref_ovf = 1'b0;
          ref_err = 1'b0;
        end
      end else begin
        ref_err = 1'b1;
      end
    end
    if (pop) void'(ref_q.pop_front());
    if (do_push) ref_q.push_back(WD[7:0]);
    ref_cnt = ref_cnt + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    Addr = a; WD = d; Strobe = s; WE = 1'b1;
    step();
    WE = 1'b0; Strobe = 4'h0;
  endtask

  task automatic clear_model();
    ref_q.delete();
    ref_ovf = 1'b0;
    ref_err = 1'b0;
    ref_cnt = '0;
  endtask

  task automatic do_reset();
    WE = 1'b0; tx_ready = 1'b0; Strobe = 4'h0;
    rst_n = 1'b0;
    #1;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    end
    do_reset();
    Addr = A_CNT_LO; #1;
    n_tests++;
    if (RD !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt_first_cycle: got %h want 0", RD);
    end
    step();
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_0002) begin
      n_fail++; $display("FAIL reset_status: got %h want 00000002", RD);
    end
  endtask

  task automatic test_ram();
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    Addr = 32'h10; WD = 32'h0000_00AA; Strobe = 4'h1; WE = 1'b1; #1;
    n_tests++;
    if (RD !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_same_cycle_old: got %h want deadbeef", RD);
    end
    step();
    WE = 1'b0; Strobe = 4'h0;
    Addr = 32'h13; #1;
    n_tests++;
    if (RD !== 32'hDEAD_BEAA || RD !== exp_rd(Addr)) begin
      n_fail++; $display("FAIL ram_strobe_merge: got %h want deadbeaa", RD);
    end
    step();
  endtask

  task automatic test_tx_fifo();
    tx_ready = 1'b0;
    wr(A_TX, 32'h41, 4'h1);
    wr(A_TX, 32'h42, 4'h1);
    wr(A_TX, 32'h43, 4'h1);
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_000C) begin
      n_fail++; $display("FAIL fifo_status_level3: got %h want 0000000c", RD);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        n_fail++; $display("FAIL fifo_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      step();
    end
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL fifo_empty_after_drain: got %b want 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_TX, 32'(8'h50 + i), 4'h1);
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_0111) begin
      n_fail++; $display("FAIL ovf_status: got %h want 00000111", RD);
    end
    wr(A_STATUS, 32'h0, 4'hF);
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_0011) begin
      n_fail++; $display("FAIL ovf_clear: got %h want 00000011", RD);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h50 + i)) begin
        n_fail++; $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h50 + i));
      end
      step();
    end
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fifth_dropped: got v=%b d=%h want v=0", tx_valid, tx_data);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'(8'h60 + i), 4'h1);
    tx_ready = 1'b1;
    wr(A_TX, 32'h64, 4'h1);
    tx_ready = 1'b0;
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_0011) begin
      n_fail++; $display("FAIL full_push_pop_status: got %h want 00000011", RD);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h61 + i)) begin
        n_fail++; $display("FAIL full_push_pop_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h61 + i));
      end
      step();
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_bus_err();
    wr(32'h0, 32'hCAFE_F00D, 4'hF);
    wr(32'h4000_0000, 32'h0000_1234, 4'hF);
    Addr = 32'h4000_0000; #1;
    n_tests++;
    if (RD !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_rd: got %h want 00000000", RD);
    end
    step();
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_0202) begin
      n_fail++; $display("FAIL bus_err_set: got %h want 00000202", RD);
    end
    step();
    Addr = 32'h0; #1;
    n_tests++;
    if (RD !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL bus_err_ram_untouched: got %h want cafef00d", RD);
    end
    step();
    wr(A_STATUS, 32'h0, 4'h0);
    Addr = 32'h4000_0004;
    step();
    Addr = A_STATUS; #1;
    n_tests++;
    if (RD !== 32'h0000_0002) begin
      n_fail++; $display("FAIL bus_err_clear_and_read_no_err: got %h want 00000002", RD);
    end
    step();
  endtask

  task automatic test_counter();
    do_reset();
    Addr = A_CNT_HI;
    repeat (10) step();
    n_tests++;
    if (RD !== 32'h0) begin
      n_fail++; $display("FAIL cnt_hi: got %h want 00000000", RD);
    end
    Addr = A_CNT_LO; #1;
    n_tests++;
    if (RD !== 32'd10 || RD !== exp_rd(Addr)) begin
      n_fail++; $display("FAIL cnt_lo_10: got %0d want 10", RD);
    end
    step();
  endtask

  task automatic test_async_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TX, 32'(8'h70 + i), 4'h1);
    tx_ready = 1'b1;
    step();
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h71) begin
      n_fail++; $display("FAIL mid_drain_head: got v=%b d=%h want v=1 d=71", tx_valid, tx_data);
    end
    Addr = A_CNT_LO;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_valid !== 1'b0 || RD !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got v=%b cnt=%h want v=0 cnt=0", tx_valid, RD);
    end
    clear_model();
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    Addr = 32'h0; #1;
    n_tests++;
    if (RD !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL ram_kept_over_reset: got %h want cafef00d", RD);
    end
    step();
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF);
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      Addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      else if (kind <= 8) Addr = 32'h8000_0000 | {28'h0, 2'($urandom), 2'b00};
      else                Addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
      WE       = ($urandom_range(0, 2) != 0);
      WD       = $urandom;
      Strobe   = 4'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      #1;
      if (rd_known(Addr)) begin
        n_tests++;
        if (RD !== exp_rd(Addr)) begin
          n_fail++; $display("FAIL rand_rd[%0d] @%h: got %h want %h", it, Addr, RD, exp_rd(Addr));
        end
      end
      n_tests++;
      if (tx_valid !== (ref_q.size() > 0) || (ref_q.size() > 0 && tx_data !== ref_q[0])) begin
        n_fail++; $display("FAIL rand_tx[%0d]: got v=%b d=%h want v=%b", it, tx_valid, tx_data, ref_q.size() > 0);
      end
      step();
    end
    WE = 1'b0; Strobe = 4'h0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_fifo();
    test_overflow();
    test_full_push_pop();
    test_bus_err();
    test_counter();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RV32I core: it sits on the far end of the core's data port (Addr/WD/WE/Strobe out, RD in). It holds a byte-strobed word RAM and a small MMIO region with a free-running 64-bit cycle counter and a byte-wide debug TX FIFO. A testbench or UART drains the FIFO over a valid/ready port. Reads are combinational, so the core sees RD in the same cycle; writes and all state updates occur on the rising clock edge.

## Interface
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of 2.
- TX_DEPTH, 4: TX FIFO depth in bytes; power of 2, minimum 2.
- MMIO_BASE, 32'h8000_0000: base of the 16-byte MMIO window.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Addr  in  32  byte address from the core.
- WD  in  32  write data, already lane-aligned by the core.
- WE  in  1  write enable.
- Strobe  in  4  byte-lane enables; bit i covers WD[8i+7:8i].
- RD  out  32  read data, combinational from Addr.
- tx_valid  out  1  FIFO head is valid.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts the head this cycle.

## Operation
- Decode uses the word address Addr[31:2]; Addr[1:0] is ignored.
  - RAM hit: Addr < MEM_WORDS*4.
  - MMIO hit: Addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- RAM read: RD = mem[Addr[log2(MEM_WORDS)+1:2]].
- RAM write: when WE=1, each lane with Strobe[i]=1 is written at the edge. Strobe=0 is a no-op.
- MMIO offsets (Addr[3:2]):
  - 0, CNT_LO: read returns counter[31:0]. Writes are ignored.
  - 1, CNT_HI: read returns counter[63:32], live value with no snapshot. Writes are ignored.
  - 2, TX_DATA: a write with Strobe[0]=1 pushes WD[7:0]. A write with Strobe[0]=0 is ignored. Reads return 0.
  - 3, STATUS: read returns bit0 full, bit1 empty, bits[7:2] FIFO level (zero-extended), bit8 overflow, bit9 bus_err; other bits are 0. Any write with WE=1 clears bits 8 and 9.
- Unmapped access:
  - Reads return 32'h0.
  - A write sets bus_err and modifies nothing.
  - A read of an unmapped address does not set bus_err.
- Counter is 64-bit, increments by 1 every cycle after reset, and wraps from 2^64-1 to 0.
- FIFO push and pop:
  - A push is accepted when level < TX_DEPTH, or when a pop happens in the same cycle (tx_valid && tx_ready).
  - A rejected push sets overflow (sticky) and drops the byte.
  - A pop happens when tx_valid && tx_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo TX_DEPTH.
- tx_valid = (level != 0). tx_data = head byte, registered storage.

## Timing
- RD has zero latency from Addr: purely combinational over RAM and MMIO registers.
- A write is visible to a read in the next cycle. Same-cycle read of a location being written returns the old value.
- Push at edge N: tx_valid=1 from edge N (visible in cycle N+1); level updates at the same edge.
- Pop at edge N: the next byte is presented in cycle N+1.
- Reset values:
  - counter=0, level=0, pointers=0, overflow=0, bus_err=0.
  - tx_valid=0; tx_data is don't-care while invalid.
  - RAM contents are not reset.
- Reset asserted mid-operation immediately empties the FIFO, zeroes the counter and clears the sticky bits. RAM keeps its contents.
- The counter value read in the cycle immediately after reset release is 0.

## Structure
- Package dmem_pkg holds:
  - offsets OFF_CNT_LO/OFF_CNT_HI/OFF_TX_DATA/OFF_STATUS;
  - STATUS bit indices ST_FULL, ST_EMPTY, ST_LEVEL_LSB, ST_OVF, ST_ERR;
  - the unmapped read value.
- Sub-module dmem_tx_fifo is a parameterised sync FIFO with push/pop/full/empty/level. The top level handles decode, RAM, counter and STATUS muxing.

## Test plan
- RAM write to 0x10 of 0xDEADBEEF with Strobe=4'b1111, then write 0x000000AA with Strobe=4'b0001 -> read 0x10 returns 0xDEADBEAA.
- Push 0x41, 0x42, 0x43 with tx_ready=0 -> STATUS level=3, empty=0. Raise tx_ready -> tx_data sequence is 0x41, 0x42, 0x43, then tx_valid drops.
- Push 5 bytes with TX_DEPTH=4 and tx_ready=0 -> STATUS reads 0x111 (full, level 4, overflow); the 5th byte is never emitted. Write STATUS -> overflow clears.
- With FIFO full, push while tx_ready=1 -> push accepted, level stays 4, overflow stays 0.
- Write 0x1234 to 0x4000_0000 -> bus_err=1, RAM unchanged, RD=0 at that address.
- Release reset, read CNT_LO 10 cycles later -> 10. Assert rst_n=0 asynchronously mid-drain -> tx_valid=0 and counter=0 before the next edge.
